// File: rtl/aes_dec_ctrl.sv
// ---------------------------------------------------------------------------
// aes_dec_ctrl -- iterative AES inverse cipher, one full round per clock.
//
// Round keys are fetched from an external key store.
// rk_addr selects a key, and rk_data must return that key in the same cycle.
// The block runs the initial AddRoundKey in the IDLE cycle that accepts start.
// It then runs NR-1 full inverse rounds in ROUND, followed by the last round
// (no InvMixColumns) in FINAL.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous active-high reset
//   start    in   1    decrypt request, only honoured in IDLE
//   ct_in    in   128  ciphertext, byte 0 in [127:120]
//   rk_addr  out  4    round-key index requested this cycle
//   rk_data  in   128  round key for rk_addr (same-cycle)
//   busy     out  1    a block is in flight
//   done     out  1    one-cycle pulse, pt_out valid from this cycle
//   pt_out   out  128  plaintext register
//
// Also in this file: the combinational helpers invshiftrows, invsubbytes
// and invmixcolumns. They can be instantiated on their own.
// ---------------------------------------------------------------------------

// InvShiftRows: row r of the 4x4 state is rotated right by r positions.
// The byte at row r, column c has index r + 4*c.
module invshiftrows (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign data_o[127-8*gi -: 8] = data_i[127-8*SRC -: 8];
  end
endmodule

// InvSubBytes: byte-wise inverse S-box lookup.
module invsubbytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign data_o[8*gi +: 8] = INV_SBOX[data_i[8*gi +: 8]];
  end
endmodule

// InvMixColumns: each 32-bit column is multiplied by the circulant matrix
// {0e,0b,0d,09} over GF(2^8). The products are built from xtime chains.
module invmixcolumns (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = data_i[127-32*gi -: 8];
    assign a1 = data_i[119-32*gi -: 8];
    assign a2 = data_i[111-32*gi -: 8];
    assign a3 = data_i[103-32*gi -: 8];
    assign data_o[127-32*gi -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    assign data_o[119-32*gi -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    assign data_o[111-32*gi -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    assign data_o[103-32*gi -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
  end
endmodule

// Controller and round datapath. NR must be 10, 12 or 14.
module aes_dec_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt_out
);
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] state_q, state_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;

  logic [127:0] isr_out, isb_out, ark_out, imc_out;

  // A single datapath serves both round flavours.
  // FINAL takes ark_out directly. ROUND takes it through InvMixColumns.
  invshiftrows  u_isr (.data_i(state_q), .data_o(isr_out));
  invsubbytes   u_isb (.data_i(isr_out), .data_o(isb_out));
  assign ark_out = isb_out ^ rk_data;
  invmixcolumns u_imc (.data_i(ark_out), .data_o(imc_out));

  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    state_d = state_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    rk_addr = NR_L;
    busy    = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        // rk_addr stays NR so that the last round key is already on
        // rk_data when start arrives.
        if (start) begin
          state_d = ct_in ^ rk_data;
          r_d     = NR_L - 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_addr = r_q;
        busy    = 1'b1;
        state_d = imc_out;
        if (r_q == 4'd1) begin
          fsm_d = FINAL;
        end else begin
          r_d = r_q - 4'd1;
        end
      end
      FINAL: begin
        rk_addr = 4'd0;
        busy    = 1'b1;
        pt_d    = ark_out;
        done_d  = 1'b1;
        fsm_d   = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      r_q     <= 4'd0;
      state_q <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      state_q <= state_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign done   = done_q;
  assign pt_out = pt_q;
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_ctrl -- scoreboard bench for aes_dec_ctrl (NR = 10).
//
// The bench computes its reference data from GF(2^8) arithmetic:
//   - the S-box and the inverse S-box
//   - the AES-128 key schedule
//   - a full inverse cipher
// It does not use any lookup table copied from the design.
// An expected {plaintext, done cycle} entry is queued whenever a start is
// driven that the DUT must accept. A monitor checks done on every cycle and
// pops an entry, and compares pt_out, whenever done is due.
// ---------------------------------------------------------------------------
module tb_aes_dec_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PROBE_IN = 128'h73d99473763e2968100c7ffc9b4bd9d2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ct_in = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;
  logic [127:0] pt_out;

  logic [127:0] probe_in = '0;
  logic [127:0] probe_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] pt;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0]   m_inv   [256];
  logic [7:0]   m_sbox  [256];
  logic [7:0]   m_isbox [256];
  logic [127:0] rk_mem  [16];

  aes_dec_ctrl #(.NR(NR)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ct_in   (ct_in),
    .rk_addr (rk_addr),
    .rk_data (rk_data),
    .busy    (busy),
    .done    (done),
    .pt_out  (pt_out)
  );

  invsubbytes u_probe (.data_i(probe_in), .data_o(probe_out));

  assign rk_data = rk_mem[rk_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] get_b(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] m_inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        o[127-8*(row+4*col) -: 8] = get_b(s, row + 4*((col + 4 - row) % 4));
    return o;
  endfunction

  function automatic logic [127:0] m_inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = m_isbox[get_b(s, k)];
    return o;
  endfunction

  function automatic logic [127:0] m_inv_mix(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [127:0] o;
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    o = '0;
    for (int col = 0; col < 4; col++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - i + 4) % 4], get_b(s, 4*col + j));
        o[127-8*(4*col+i) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk_mem[NR];
    for (int rnd = NR - 1; rnd >= 1; rnd--) s = m_inv_mix(m_inv_sub(m_inv_shift(s)) ^ rk_mem[rnd]);
    return m_inv_sub(m_inv_shift(s)) ^ rk_mem[0];
  endfunction

  task automatic push_exp(input logic [127:0] pt, input int at_cyc);
    exp_t e;
    e.pt  = pt;
    e.cyc = at_cyc;
    sb_q.push_back(e);
  endtask

  // Build the GF tables, the S-boxes and the AES-128 key schedule.
  task automatic build_model();
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [7:0]   a;
    logic [127:0] key_v;
    for (int x = 0; x < 256; x++) begin
      m_inv[x] = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) m_inv[x] = 8'(y);
    end
    for (int x = 0; x < 256; x++) begin
      a = m_inv[x];
      m_sbox[x] = a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
      a = 8'(x);
      m_isbox[x] = m_inv[rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05];
    end
    key_v = KEY;
    for (int i = 0; i < 4; i++) w[i] = key_v[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    for (int i = 0; i <= NR; i++) rk_mem[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endtask

  // Scoreboard monitor: done must match the queue head on every cycle.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    exp_done = (sb_q.size() != 0) && (sb_q[0].cyc == cyc);
    check_eq("done", 128'(done), 128'(exp_done));
    if (exp_done) begin
      e = sb_q.pop_front();
      check_eq("pt_out", pt_out, e.pt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    int exp_rk;
    logic [127:0] ct_r;

    build_model();

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_pt_out", pt_out, 128'(0));
    check_eq("rst_rk_addr", 128'(rk_addr), 128'(NR));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // C.1 vector, with the rk_addr sequence, the busy length, ct_in
    // changing after acceptance, and the standalone invsubbytes probe.
    n = cyc;
    check_eq("idle_busy", 128'(busy), 128'(0));
    check_eq("rk_addr_k0", 128'(rk_addr), 128'(NR));
    start = 1'b1;
    ct_in = C1_CT;
    push_exp(C1_PT, n + NR + 1);
    busy_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        ct_in = {$urandom, $urandom, $urandom, $urandom};
      end
      exp_rk = (k <= NR - 1) ? NR - k : (k == NR) ? 0 : NR;
      check_eq($sformatf("rk_addr_k%0d", k), 128'(rk_addr), 128'(exp_rk));
      if (busy) busy_cnt++;
      if (k == NR) begin
        probe_in = PROBE_IN;
        #1;
        check_eq("isb_probe", probe_out, m_inv_sub(PROBE_IN));
      end
    end
    check_eq("busy_cycles", 128'(busy_cnt), 128'(NR));
    check_eq("pending_c1", 128'(sb_q.size()), 128'(0));
    repeat (3) @(negedge clk);
    check_eq("pt_hold", pt_out, C1_PT);

    // A start pulsed while busy is ignored.
    n = cyc;
    start = 1'b1;
    ct_in = C1_CT;
    push_exp(C1_PT, n + NR + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    ct_in = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pending_busyrej", 128'(sb_q.size()), 128'(0));
    repeat (3) @(negedge clk);

    // Back-to-back: start held high across two blocks.
    n = cyc;
    start = 1'b1;
    ct_in = C1_CT;
    push_exp(C1_PT, n + NR + 1);
    push_exp(model_dec('0), n + 2 * (NR + 1));
    @(negedge clk);
    ct_in = '0;
    repeat (NR + 1) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("pending_b2b", 128'(sb_q.size()), 128'(0));

    // Random blocks checked against the model.
    for (int b = 0; b < 3; b++) begin
      ct_r = {$urandom, $urandom, $urandom, $urandom};
      n = cyc;
      start = 1'b1;
      ct_in = ct_r;
      push_exp(model_dec(ct_r), n + NR + 1);
      @(negedge clk);
      start = 1'b0;
      repeat (NR + 2) @(negedge clk);
    end
    check_eq("pending_rand", 128'(sb_q.size()), 128'(0));

    // Reset mid-operation aborts the block and produces no done.
    n = cyc;
    start = 1'b1;
    ct_in = C1_CT;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 128'(busy), 128'(0));
    check_eq("abort_pt_out", pt_out, 128'(0));
    check_eq("abort_rk_addr", 128'(rk_addr), 128'(NR));
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("abort_rk_idle", 128'(rk_addr), 128'(NR));

    // A fresh C.1 start after the abort.
    n = cyc;
    start = 1'b1;
    ct_in = C1_CT;
    push_exp(C1_PT, n + NR + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (NR + 3) @(negedge clk);
    check_eq("pending_restart", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 The block SHALL have one parameter: NR, default 10, number of AES rounds; legal values 10, 12 and 14.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to decrypt ct_in; sampled only in IDLE.
REQ-006 ct_in  input  128  ciphertext; byte 0 is in bits [127:120].
REQ-007 rk_addr  output  4  index of the round key requested this cycle.
REQ-008 rk_data  input  128  round key for rk_addr; valid combinationally in the same cycle.
REQ-009 busy  output  1  high while a block is in flight.
REQ-010 done  output  1  one-cycle pulse; pt_out is valid from this cycle.
REQ-011 pt_out  output  128  plaintext register.

Function
REQ-012 The block SHALL instantiate the codebase's combinational invshiftrows, invsubbytes and invmixcolumns modules, with AddRoundKey as a 128-bit XOR; one full round is computed per cycle.
REQ-013 The FSM SHALL have three states: IDLE, ROUND and FINAL; a 4-bit round counter r SHALL be kept alongside it.
REQ-014 IDLE: rk_addr = NR; busy = 0.
REQ-015 IDLE with start = 1: on the edge, state_reg <= ct_in ^ rk_data, r <= NR-1, and the FSM moves to ROUND.
REQ-016 IDLE with start = 0: state_reg holds and the FSM stays in IDLE.
REQ-017 ROUND: rk_addr = r; busy = 1; on the edge, state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data).
REQ-018 ROUND: if r = 1, the FSM moves to FINAL; otherwise r <= r-1.
REQ-019 FINAL: rk_addr = 0; busy = 1; on the edge, pt_out <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data, done <= 1, and the FSM moves to IDLE.
REQ-020 Latency: if start is accepted in cycle N, done SHALL be high in cycle N+NR+1 (N+11 for NR = 10); busy SHALL be high in cycles N+1 through N+NR.
REQ-021 done SHALL be high for exactly one cycle per accepted start; done = 0 in every other cycle.
REQ-022 pt_out SHALL hold its value until the next FINAL-to-IDLE transition.
REQ-023 start while busy = 1 SHALL be ignored; no queuing; the in-flight operation is unaffected.
REQ-024 start in the cycle done is high SHALL be accepted, because the FSM is already in IDLE; back-to-back throughput is one block per NR+1 cycles.
REQ-025 ct_in SHALL be sampled only on the accepting edge; later changes to ct_in SHALL have no effect.
REQ-026 rk_addr SHALL be a pure function of the FSM state and r, with no combinational path from start or ct_in.

Reset
REQ-027 rst = 1 on an edge SHALL force: FSM = IDLE, r = 0, busy = 0, done = 0, pt_out = 0, state_reg = 0.
REQ-028 rst SHALL take priority over start and SHALL abort an in-flight operation; no done pulse SHALL be produced for the aborted block.
REQ-029 During and after reset, rk_addr = NR until the next start.

Verification
REQ-030 FIPS-197 C.1 vector, NR = 10: bench supplies key-expansion words for key 000102030405060708090a0b0c0d0e0f from a model indexed by rk_addr; start with ct_in = 69c4e0d86a7b0430d8cdb78070b4c55a -> done in cycle N+11 and pt_out = 00112233445566778899aabbccddeeff.
REQ-031 rk_addr sequence: for the C.1 run, rk_addr SHALL read 10 (start cycle), then 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, then 10; busy SHALL be high for exactly 10 cycles.
REQ-032 Busy rejection: start pulsed again at N+4 with a different ct_in -> exactly one done, at N+11, with the C.1 plaintext.
REQ-033 Back-to-back: start held high continuously for two blocks (C.1 ciphertext, then all-zero ciphertext) -> done in cycles N+11 and N+22; second pt_out equals the reference-model decryption of the all-zero block.
REQ-034 Reset mid-operation: rst asserted at N+5 for one cycle -> busy = 0, done = 0 and pt_out = 0 from N+6; no done pulse follows; a fresh C.1 start then completes correctly.
REQ-035 Cross-check: invsubbytes input 73d99473763e2968100c7ffc9b4bd9d2 matches the standalone invsubbytes output when probed during the final round.
